uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1000000, clk cycles a locked requester may hold valid low before its lock is revoked.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester byte valid.
REQ-006 SHALL have port req_data  input  8*NREQ  per-requester byte, requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  NREQ  byte is last of message; releases lock.
REQ-008 SHALL have port req_ready  output  NREQ  one-cycle accept pulse, one-hot or zero.
REQ-009 SHALL have port tx_data  output  8  byte to the transmitter core.
REQ-010 SHALL have port tx_wr  output  1  one-cycle write strobe to the transmitter core.
REQ-011 SHALL have port tx_busy  input  1  transmitter busy; rises the cycle after tx_wr and stays high until the frame, stop and break bits complete.
REQ-012 SHALL have port grant_id  output  3  index of the current or last granted requester.
REQ-013 SHALL have port locked  output  1  a message is in progress for grant_id.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE, unlocked: any req_valid set -> select a requester by round-robin, starting the search at rr_ptr and wrapping from NREQ-1 to 0; latch grant_id; go to ISSUE.
REQ-016 IDLE, locked: req_valid[grant_id] set -> ISSUE; other requesters SHALL be ignored.
REQ-017 ISSUE (exactly 1 cycle): tx_wr=1; tx_data=req_data[grant_id]; req_ready[grant_id]=1; lock cleared if req_last[grant_id]=1, else set; -> WAIT_BUSY.
REQ-018 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; otherwise hold.
REQ-019 WAIT_DONE: tx_busy=0 -> IDLE.
REQ-020 On lock release, rr_ptr SHALL become (grant_id+1) mod NREQ; rr_ptr SHALL be unchanged while locked.
REQ-021 Byte-to-byte latency SHALL be 3 clk from tx_busy falling to the next tx_wr: WAIT_DONE->IDLE, IDLE->ISSUE, ISSUE asserts tx_wr.
REQ-022 tx_data SHALL be registered and held stable from ISSUE until the next ISSUE.
REQ-023 The lock counter SHALL count IDLE cycles with locked=1 and req_valid[grant_id]=0, and clear when valid is seen.
REQ-024 When the lock counter reaches LOCK_TIMEOUT-1, locked SHALL clear and rr_ptr SHALL advance as in REQ-020; no byte is sent.
REQ-025 Simultaneous requests SHALL produce exactly one grant; the others wait without a req_ready pulse.
REQ-026 A requester dropping valid outside ISSUE SHALL have no effect on the current transmission.
REQ-027 req_valid changes during WAIT_BUSY or WAIT_DONE SHALL be ignored until IDLE.

Reset
REQ-028 On reset the block SHALL be in IDLE with tx_wr=0, req_ready=0, tx_data=0, grant_id=0, locked=0, rr_ptr=0 and the lock counter at 0.
REQ-029 Reset mid-operation SHALL abort without a further tx_wr; the transmitter is reset by the same signal.

Structure
REQ-030 Shared package uart_pkg SHALL hold the arbiter state enum and the UART_BYTE_W=8 constant.
REQ-031 The round-robin picker SHALL be a sub-module, uart_rr_pick: inputs request vector and rr_ptr; outputs a valid flag and the index.

Verification
REQ-032 Single request: req_valid[2]=1, data 0x41, last=1 -> one tx_wr with tx_data=0x41; req_ready[2] pulses the same cycle; then locked=0 and rr_ptr=3.
REQ-033 Contention: all 4 valid, each last=1, rr_ptr=0 -> grant order 0,1,2,3; exactly 4 tx_wr pulses.
REQ-034 Lock: req 1 sends 0x48,0x49 (last on 0x49) while req 0 is valid -> both req-1 bytes are sent before any req-0 byte.
REQ-035 Timeout: LOCK_TIMEOUT=16; req 3 sends 0x55 with last=0, then drops valid; req 0 valid -> locked clears after 16 idle cycles and req 0 is granted next.
REQ-036 Wrap: rr_ptr=3, requests on 0 and 3 -> 3 is granted first, then 0.
REQ-037 Reset asserted in WAIT_BUSY -> next cycle all outputs are at reset values and no tx_wr follows until a new request arrives.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;
    localparam int unsigned GRANT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } arb_state_e;

    // Requester index following idx, wrapping at nreq.
    function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx,
                                                   input int unsigned nreq);
        return (32'(idx) + 32'd1 >= nreq) ? '0 : idx + GRANT_W'(1);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping to 0.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]    req,
    input  logic [GRANT_W-1:0] ptr,
    output logic               valid,
    output logic [GRANT_W-1:0] idx
);

    localparam int unsigned SUM_W = GRANT_W + 1;

    logic [2*NREQ-1:0]  dbl;
    logic [NREQ-1:0]    rot;
    logic [GRANT_W-1:0] off;
    logic [SUM_W-1:0]   sum;

    // Rotate so that bit 0 is the requester at ptr.
    assign dbl = {req, req};
    assign rot = NREQ'(dbl >> ptr);

    always_comb begin
        valid = 1'b0;
        off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                off   = GRANT_W'(k);
            end
        end
    end

    assign sum = SUM_W'(ptr) + SUM_W'(off);
    assign idx = (32'(sum) >= NREQ) ? GRANT_W'(sum - SUM_W'(NREQ)) : GRANT_W'(sum);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte requesters onto one UART transmitter, with per-message lock
// and a timeout that revokes a lock held by a silent requester.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned LOCK_TIMEOUT = 1000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]             req_last,
    output logic [NREQ-1:0]             req_ready,
    output logic [UART_BYTE_W-1:0]      tx_data,
    output logic                        tx_wr,
    input  logic                        tx_busy,
    output logic [GRANT_W-1:0]          grant_id,
    output logic                        locked
);

    localparam int unsigned    CNT_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    arb_state_e             state, state_nx;
    logic [GRANT_W-1:0]     rr_ptr, rr_nx;
    logic [CNT_W-1:0]       lock_cnt, cnt_nx;
    logic                   last_q, last_nx;
    logic [GRANT_W-1:0]     grant_nx;
    logic                   locked_nx;
    logic [UART_BYTE_W-1:0] data_nx;
    logic                   wr_nx;
    logic [NREQ-1:0]        ready_nx;

    logic                   pick_valid;
    logic [GRANT_W-1:0]     pick_idx;
    logic [GRANT_W-1:0]     target;
    logic                   tgt_valid;
    logic                   tgt_last;
    logic [UART_BYTE_W-1:0] tgt_data;

    uart_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A locked message owns the channel; otherwise the round-robin winner does.
    assign target = locked ? grant_id : pick_idx;

    always_comb begin
        tgt_valid = 1'b0;
        tgt_last  = 1'b0;
        tgt_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (target == GRANT_W'(i)) begin
                tgt_valid = req_valid[i];
                tgt_last  = req_last[i];
                tgt_data  = req_data[i*UART_BYTE_W +: UART_BYTE_W];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        rr_nx     = rr_ptr;
        cnt_nx    = lock_cnt;
        last_nx   = last_q;
        grant_nx  = grant_id;
        locked_nx = locked;
        data_nx   = tx_data;
        wr_nx     = 1'b0;
        ready_nx  = '0;

        case (state)
            ST_IDLE: begin
                if ((locked && tgt_valid) || (!locked && pick_valid)) begin
                    state_nx = ST_ISSUE;
                    grant_nx = target;
                    data_nx  = tgt_data;
                    last_nx  = tgt_last;
                    wr_nx    = 1'b1;
                    ready_nx = NREQ'(1) << target;
                    cnt_nx   = '0;
                end else if (locked) begin
                    // Owner has gone quiet: give up the lock after the timeout.
                    if (lock_cnt == CNT_LAST) begin
                        locked_nx = 1'b0;
                        rr_nx     = rr_next(grant_id, NREQ);
                        cnt_nx    = '0;
                    end else begin
                        cnt_nx = lock_cnt + CNT_W'(1);
                    end
                end
            end
            ST_ISSUE: begin
                state_nx = ST_WAIT_BUSY;
                if (last_q) begin
                    locked_nx = 1'b0;
                    rr_nx     = rr_next(grant_id, NREQ);
                end else begin
                    locked_nx = 1'b1;
                end
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) state_nx = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            lock_cnt  <= '0;
            last_q    <= 1'b0;
            grant_id  <= '0;
            locked    <= 1'b0;
            tx_data   <= '0;
            tx_wr     <= 1'b0;
            req_ready <= '0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_nx;
            lock_cnt  <= cnt_nx;
            last_q    <= last_nx;
            grant_id  <= grant_nx;
            locked    <= locked_nx;
            tx_data   <= data_nx;
            tx_wr     <= wr_nx;
            req_ready <= ready_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter with a transmitter model
// and a round-robin/lock reference model.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned LT   = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_ready;
    logic [7:0]          tx_data;
    logic                tx_wr;
    logic                tx_busy;
    logic [2:0]          grant_id;
    logic                locked;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(LT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    // Transmitter: busy from the cycle after tx_wr for a random 2..5 cycles.
    int busy_left;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy   <= 1'b0;
            busy_left <= 0;
        end else if (tx_wr) begin
            tx_busy   <= 1'b1;
            busy_left <= int'($urandom_range(4, 1));
        end else if (tx_busy) begin
            if (busy_left == 0) tx_busy <= 1'b0;
            else                busy_left <= busy_left - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [7:0] d, input bit l);
        req_valid[i]       = v;
        req_data[i*8 +: 8] = d;
        req_last[i]        = l;
    endtask

    task automatic wait_wr(input string tag);
        int n = 0;
        @(negedge clk);
        while (!tx_wr && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wr_seen"}, 32'(tx_wr), 1);
    endtask

    // Waits through the current frame and measures busy-fall to next tx_wr.
    task automatic wait_lat(input string tag);
        int n = 0;
        while (!tx_busy && n < 30) begin @(negedge clk); n++; end
        n = 0;
        while (tx_busy && n < 30) begin @(negedge clk); n++; end
        n = 1;
        while (!tx_wr && n < 30) begin @(negedge clk); n++; end
        chk({tag, "_lat"}, n, 3);
    endtask

    task automatic count_wr(input int cyc, output int n);
        n = 0;
        repeat (cyc) begin
            @(negedge clk);
            if (tx_wr) n++;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    function automatic int rr_model(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < int'(NREQ); k++) begin
            if (v[(ptr + k) % int'(NREQ)]) return (ptr + k) % int'(NREQ);
        end
        return -1;
    endfunction

    int              n;
    int              rem [NREQ];
    int              gap [NREQ];
    int              msgs[NREQ];
    logic [7:0]      cur_d[NREQ];
    bit              cur_l[NREQ];
    bit              m_locked;
    int              m_owner, m_rr, e, cyc, nbytes, exp_bytes, pending;
    logic [NREQ-1:0] vld_dec;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (2) @(negedge clk);
        chk("rst_tx_wr",  32'(tx_wr),     0);
        chk("rst_ready",  32'(req_ready), 0);
        chk("rst_data",   32'(tx_data),   0);
        chk("rst_grant",  32'(grant_id),  0);
        chk("rst_locked", 32'(locked),    0);
        reset = 1'b0;
        @(negedge clk);

        // Single request from requester 2
        set_req(2, 1, 8'h41, 1);
        wait_wr("single");
        chk("single_data",  32'(tx_data),   32'h41);
        chk("single_ready", 32'(req_ready), 32'b0100);
        chk("single_grant", 32'(grant_id),  2);
        set_req(2, 0, 8'h00, 0);
        count_wr(20, n);
        chk("single_extra_wr", n, 0);
        chk("single_locked", 32'(locked), 0);

        // Wrap: pointer now at 3, requests on 0 and 3
        set_req(0, 1, 8'h10, 1);
        set_req(3, 1, 8'h13, 1);
        wait_wr("wrap_a");
        chk("wrap_a_grant", 32'(grant_id), 3);
        chk("wrap_a_data",  32'(tx_data),  32'h13);
        set_req(3, 0, 8'h00, 0);
        wait_lat("wrap_b");
        chk("wrap_b_grant", 32'(grant_id), 0);
        chk("wrap_b_data",  32'(tx_data),  32'h10);
        set_req(0, 0, 8'h00, 0);

        // Contention from a fresh pointer
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 1, 8'hA0 + 8'(k), 1);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) wait_wr("cont");
            else        wait_lat("cont");
            chk("cont_grant", 32'(grant_id),  k);
            chk("cont_data",  32'(tx_data),   32'hA0 + k);
            chk("cont_ready", 32'(req_ready), 32'(1) << k);
            set_req(k, 0, 8'h00, 0);
        end
        count_wr(30, n);
        chk("cont_extra_wr", n, 0);

        // Lock: two-byte message from 1 while 0 waits
        set_req(1, 1, 8'h48, 0);
        wait_wr("lock_b0");
        chk("lock_b0_grant", 32'(grant_id), 1);
        chk("lock_b0_data",  32'(tx_data),  32'h48);
        set_req(1, 1, 8'h49, 1);
        set_req(0, 1, 8'h30, 1);
        @(negedge clk);
        chk("lock_held", 32'(locked), 1);
        wait_lat("lock_b1");
        chk("lock_b1_grant", 32'(grant_id), 1);
        chk("lock_b1_data",  32'(tx_data),  32'h49);
        set_req(1, 0, 8'h00, 0);
        wait_lat("lock_r0");
        chk("lock_r0_grant", 32'(grant_id), 0);
        chk("lock_r0_data",  32'(tx_data),  32'h30);
        set_req(0, 0, 8'h00, 0);

        // Timeout: 3 locks and goes quiet, 0 waits
        set_req(3, 1, 8'h55, 0);
        wait_wr("to");
        chk("to_grant", 32'(grant_id), 3);
        chk("to_data",  32'(tx_data),  32'h55);
        set_req(3, 0, 8'h00, 0);
        set_req(0, 1, 8'h77, 1);
        n = 0;
        while (!tx_busy && n < 30) begin @(negedge clk); n++; end
        n = 0;
        while (tx_busy && n < 30) begin @(negedge clk); n++; end
        n = 0;
        while (locked && !tx_wr && n < 60) begin n++; @(negedge clk); end
        chk("to_locked_cycles", n, 1 + LT);
        chk("to_no_wr", 32'(tx_wr), 0);
        wait_wr("to_next");
        chk("to_next_grant", 32'(grant_id), 0);
        chk("to_next_data",  32'(tx_data),  32'h77);
        set_req(0, 0, 8'h00, 0);

        // Reset while waiting for busy
        set_req(1, 1, 8'h5A, 1);
        wait_wr("rmid");
        @(negedge clk);
        reset = 1'b1;
        set_req(1, 0, 8'h00, 0);
        #1;
        chk("rmid_tx_wr",  32'(tx_wr),     0);
        chk("rmid_ready",  32'(req_ready), 0);
        chk("rmid_data",   32'(tx_data),   0);
        chk("rmid_grant",  32'(grant_id),  0);
        chk("rmid_locked", 32'(locked),    0);
        @(negedge clk);
        reset = 1'b0;
        count_wr(20, n);
        chk("rmid_no_wr", n, 0);

        // Random multi-byte messages against the reference model
        do_reset();
        exp_bytes = 0;
        nbytes    = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            msgs[i] = int'($urandom_range(4, 2));
            rem[i]  = 0;
            gap[i]  = int'($urandom_range(8, 0));
        end
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = 0;
        cyc      = 0;
        pending  = 1;
        while (pending != 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            vld_dec = req_valid;
            if (tx_wr) begin
                e = m_locked ? m_owner : rr_model(vld_dec, m_rr);
                chk("rnd_grant", 32'(grant_id), e);
                if (e >= 0) begin
                    chk("rnd_data",  32'(tx_data),   32'(cur_d[e]));
                    chk("rnd_ready", 32'(req_ready), 32'(1) << e);
                    if (cur_l[e]) begin
                        m_locked = 1'b0;
                        m_rr     = (e + 1) % int'(NREQ);
                    end else begin
                        m_locked = 1'b1;
                        m_owner  = e;
                    end
                end
                nbytes++;
            end else begin
                chk("rnd_locked",   32'(locked),    32'(m_locked));
                chk("rnd_ready_lo", 32'(req_ready), 0);
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) msgs[i]--;
                    set_req(i, 0, 8'h00, 0);
                    gap[i] = int'($urandom_range(3, 0));
                end else if (!req_valid[i]) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else if (msgs[i] > 0) begin
                        if (rem[i] == 0) begin
                            rem[i]    = int'($urandom_range(3, 1));
                            exp_bytes += rem[i];
                        end
                        cur_d[i] = 8'($urandom);
                        cur_l[i] = (rem[i] == 1);
                        set_req(i, 1, cur_d[i], cur_l[i]);
                    end
                end
            end
            pending = 0;
            for (int i = 0; i < int'(NREQ); i++) pending += msgs[i];
            if (req_valid != '0) pending++;
        end
        chk("rnd_in_time", 32'(cyc < 4000), 1);
        chk("rnd_bytes", nbytes, exp_bytes);
        count_wr(20, n);
        chk("rnd_extra_wr", n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
